// File: rtl/ret_shadow_stack_pkg.sv
// Shared types and constants for the commit-stage return shadow stack.
// Provides address widths, the exception bundle, the violation cause and untag().
package ret_shadow_stack_pkg;

    localparam int VLEN        = 39;
    localparam int XLEN        = 64;
    localparam int SHSTK_DEPTH = 16;

    localparam logic [XLEN-1:0] INSTR_ACCESS_FAULT = 64'd1;
    localparam logic [XLEN-1:0] SHSTK_VIOLATION    = INSTR_ACCESS_FAULT;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    // Strip the link-address tag so tagged and untagged copies compare equal.
    function automatic logic [VLEN-1:0] untag(
        input logic [VLEN-1:0] addr,
        input int unsigned     bit_pos
    );
        logic [VLEN-1:0] r;
        r          = addr;
        r[bit_pos] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/ret_shadow_stack_if.sv
// Committed control-flow event bundle from the commit stage.
// master: commit logic drives; slave: shadow stack observes.
interface ret_shadow_stack_if
    import ret_shadow_stack_pkg::*;
#(
    parameter int W = ret_shadow_stack_pkg::VLEN
);
    logic         commit_valid;
    logic         is_call;
    logic         is_ret;
    logic [W-1:0] pc;
    logic         is_compressed;
    logic [W-1:0] target;

    modport master (
        output commit_valid, is_call, is_ret,
        output pc, is_compressed, target
    );

    modport slave (
        input commit_valid, is_call, is_ret,
        input pc, is_compressed, target
    );
endinterface

// File: rtl/shadow_stack_lifo.sv
// Circular LIFO: overwrite-oldest on full, pop-then-push in one cycle.
// Ports: clear/push/pop/data in; top entry, empty, depth, overwrite flag out.
module shadow_stack_lifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 39
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           top_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       overwrite_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    top_q, top_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic             pop_ok;

    assign pop_ok  = pop_i & (depth_q != '0);
    assign top_o   = mem_q[top_q];
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    always_comb begin
        top_d       = top_q;
        depth_d     = depth_q;
        wr_en       = 1'b0;
        wr_idx      = top_q;
        overwrite_o = 1'b0;
        if (clear_i) begin
            top_d   = '0;
            depth_d = '0;
        end else if (pop_ok && push_i) begin
            // Coroutine swap: replace the top in place.
            wr_en = 1'b1;
        end else if (push_i) begin
            wr_en  = 1'b1;
            wr_idx = top_q + PW'(1);
            top_d  = top_q + PW'(1);
            // At full, top+1 is the oldest slot and gets overwritten.
            if (depth_q == DW'(DEPTH)) begin
                overwrite_o = 1'b1;
            end else begin
                depth_d = depth_q + DW'(1);
            end
        end else if (pop_ok) begin
            top_d   = top_q - PW'(1);
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            top_q   <= '0;
            depth_q <= '0;
        end else begin
            top_q   <= top_d;
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/ret_shadow_stack.sv
// Commit-stage return-address shadow stack with held violation exception.
// Ports: clk/rst, en/debug/clear, commit event bundle, ack; exception, depth, counters.
module ret_shadow_stack
    import ret_shadow_stack_pkg::*;
#(
    parameter int DEPTH   = ret_shadow_stack_pkg::SHSTK_DEPTH,
    parameter int VLEN    = ret_shadow_stack_pkg::VLEN,
    parameter int TAG_BIT = VLEN - 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       debug_mode_i,
    input  logic                       clear_i,
    ret_shadow_stack_if.slave          cmt,
    input  logic                       violation_ack_i,
    output exception_t                 violation_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic [15:0]                overflow_cnt_o,
    output logic                       underflow_o
);
    logic            active;
    logic            push;
    logic            pop_req;
    logic            pop_hit;
    logic            mismatch;
    logic            empty;
    logic            overwrite;
    logic [VLEN-1:0] top;
    logic [VLEN-1:0] link;
    logic [VLEN-1:0] ret_tgt;
    logic [VLEN-1:0] step;
    logic [XLEN-1:0] pc_sext;

    logic            vld_q, vld_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [15:0]     ovf_cnt_q, ovf_cnt_d;
    logic            uf_q, uf_d;

    assign active  = cmt.commit_valid & en_i & ~debug_mode_i;
    assign push    = active & cmt.is_call & ~clear_i;
    assign pop_req = active & cmt.is_ret & ~clear_i;
    assign pop_hit = pop_req & ~empty;

    assign step     = cmt.is_compressed ? VLEN'(2) : VLEN'(4);
    assign link     = untag(cmt.pc + step, TAG_BIT);
    assign ret_tgt  = untag(cmt.target, TAG_BIT);
    assign mismatch = pop_hit & (ret_tgt != top);
    assign pc_sext  = {{(XLEN-VLEN){cmt.pc[VLEN-1]}}, cmt.pc};

    shadow_stack_lifo #(
        .DEPTH (DEPTH),
        .WIDTH (VLEN)
    ) u_lifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .push_i      (push),
        .pop_i       (pop_req),
        .data_i      (link),
        .top_o       (top),
        .empty_o     (empty),
        .depth_o     (depth_o),
        .overwrite_o (overwrite)
    );

    always_comb begin
        vld_d     = vld_q;
        tval_d    = tval_q;
        ovf_cnt_d = ovf_cnt_q;
        uf_d      = pop_req & empty;
        if (violation_ack_i) begin
            vld_d = 1'b0;
        end
        // First violation wins unless the pending one is retired now.
        if (mismatch && (!vld_q || violation_ack_i)) begin
            vld_d  = 1'b1;
            tval_d = pc_sext;
        end
        if (overwrite && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= 1'b0;
            tval_q    <= '0;
            ovf_cnt_q <= '0;
            uf_q      <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            tval_q    <= tval_d;
            ovf_cnt_q <= ovf_cnt_d;
            uf_q      <= uf_d;
        end
    end

    assign violation_o.valid = vld_q;
    assign violation_o.cause = SHSTK_VIOLATION;
    assign violation_o.tval  = tval_q;
    assign overflow_cnt_o    = ovf_cnt_q;
    assign underflow_o       = uf_q;

endmodule

// File: tb/tb_ret_shadow_stack.sv
// Scoreboard bench for ret_shadow_stack: directed events, queued expectations.
// Monitor compares depth, overflow count, underflow and violation every cycle.
module tb_ret_shadow_stack;
    import ret_shadow_stack_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, dbg, clr, ack;
    exception_t  viol;
    logic [4:0]  depth;
    logic [15:0] ovf;
    logic        uf;

    always #5 clk = ~clk;

    ret_shadow_stack_if #(.W(39)) cmt_if ();

    ret_shadow_stack #(.DEPTH(16)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .debug_mode_i    (dbg),
        .clear_i         (clr),
        .cmt             (cmt_if),
        .violation_ack_i (ack),
        .violation_o     (viol),
        .depth_o         (depth),
        .overflow_cnt_o  (ovf),
        .underflow_o     (uf)
    );

    typedef struct {
        int          due;
        string       name;
        logic [4:0]  d;
        logic [15:0] o;
        logic        u;
        logic        v;
        logic [63:0] t;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input string fld,
                                input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk(e.name, "depth", 64'(depth), 64'(e.d));
                chk(e.name, "ovf", 64'(ovf), 64'(e.o));
                chk(e.name, "uf", 64'(uf), 64'(e.u));
                chk(e.name, "valid", 64'(viol.valid), 64'(e.v));
                if (e.v) chk(e.name, "cause", viol.cause, 64'd1);
                chk(e.name, "tval", viol.tval, e.t);
            end
        end
    end

    task automatic drv(
        input string       nm,
        input logic        r, c, e_, g, cv, ca, rt,
        input logic [38:0] pc,
        input logic        cm,
        input logic [38:0] tg,
        input logic        a,
        input logic [4:0]  ed,
        input logic [15:0] eo,
        input logic        eu, ev,
        input logic [63:0] et
    );
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; clr = c; en = e_; dbg = g; ack = a;
        cmt_if.commit_valid  = cv;
        cmt_if.is_call       = ca;
        cmt_if.is_ret        = rt;
        cmt_if.pc            = pc;
        cmt_if.is_compressed = cm;
        cmt_if.target        = tg;
        x.due = cyc + 1; x.name = nm;
        x.d = ed; x.o = eo; x.u = eu; x.v = ev; x.t = et;
        sb.push_back(x);
    endtask

    task automatic call(input string nm, input logic [38:0] pc, input logic cm,
                        input logic [4:0] ed, input logic [15:0] eo,
                        input logic eu, ev, input logic [63:0] et);
        drv(nm, 0, 0, 1, 0, 1, 1, 0, pc, cm, '0, 0, ed, eo, eu, ev, et);
    endtask

    task automatic ret(input string nm, input logic [38:0] pc, input logic [38:0] tg,
                       input logic a, input logic [4:0] ed, input logic [15:0] eo,
                       input logic eu, ev, input logic [63:0] et);
        drv(nm, 0, 0, 1, 0, 1, 0, 1, pc, 0, tg, a, ed, eo, eu, ev, et);
    endtask

    task automatic coro(input string nm, input logic [38:0] pc, input logic cm,
                        input logic [38:0] tg, input logic [4:0] ed,
                        input logic [15:0] eo, input logic eu, ev,
                        input logic [63:0] et);
        drv(nm, 0, 0, 1, 0, 1, 1, 1, pc, cm, tg, 0, ed, eo, eu, ev, et);
    endtask

    task automatic idle(input string nm, input logic a, input logic [4:0] ed,
                        input logic [15:0] eo, input logic eu, ev,
                        input logic [63:0] et);
        drv(nm, 0, 0, 1, 0, 0, 0, 0, '0, 0, '0, a, ed, eo, eu, ev, et);
    endtask

    localparam logic [63:0] T2 = 64'h8000_0600;
    localparam logic [63:0] TS = 64'hFFFF_FFC0_0000_1000;

    initial begin
        rst = 1; en = 0; dbg = 0; clr = 0; ack = 0;
        cmt_if.commit_valid = 0; cmt_if.is_call = 0; cmt_if.is_ret = 0;
        cmt_if.pc = '0; cmt_if.is_compressed = 0; cmt_if.target = '0;

        drv("reset0", 1, 0, 1, 0, 1, 1, 0, 39'h100, 0, '0, 0, 0, 0, 0, 0, 0);
        drv("reset1", 1, 0, 1, 0, 0, 0, 0, '0, 0, '0, 0, 0, 0, 0, 0, 0);

        call("t1_call", 39'h8000_0100, 0, 1, 0, 0, 0, 0);
        ret("t1_ret", 39'h8000_0500, 39'h20_8000_0104, 0, 0, 0, 0, 0, 0);

        call("t2_call", 39'h8000_0200, 1, 1, 0, 0, 0, 0);
        ret("t2_ret", 39'h8000_0600, 39'h8000_0300, 0, 0, 0, 0, 1, T2);
        idle("t2_hold", 0, 0, 0, 0, 1, T2);
        idle("t2_ack", 1, 0, 0, 0, 0, T2);

        for (int i = 0; i < 17; i++)
            call($sformatf("t3_call%0d", i), 39'(32'h1000 + i * 16), 0,
                 5'((i < 16) ? i + 1 : 16), 16'((i == 16) ? 1 : 0), 0, 0, T2);
        for (int k = 0; k < 16; k++)
            ret($sformatf("t3_ret%0d", k), 39'h2000,
                39'(32'h1004 + (16 - k) * 16), 0, 5'(15 - k), 1, 0, 0, T2);
        ret("t3_ret_empty", 39'h2000, 39'h1004, 0, 0, 1, 1, 0, T2);
        idle("t3_idle", 0, 0, 1, 0, 0, T2);

        ret("t4_ret_empty", 39'h2100, 39'h0, 0, 0, 1, 1, 0, T2);
        coro("t4_coro_empty", 39'h3000, 0, 39'h9999, 1, 1, 1, 0, T2);
        ret("t4_ret_link", 39'h3100, 39'h3004, 0, 0, 1, 0, 0, T2);
        call("t4_call", 39'h4000, 0, 1, 1, 0, 0, T2);
        coro("t4_coro", 39'h5000, 1, 39'h4004, 1, 1, 0, 0, T2);
        ret("t4_ret_swap", 39'h5100, 39'h5002, 0, 0, 1, 0, 0, T2);

        call("t5_call_a", 39'h6000, 0, 1, 1, 0, 0, T2);
        call("t5_call_b", 39'h6100, 0, 2, 1, 0, 0, T2);
        ret("t5_mis1", 39'h40_0000_1000, 39'h7777, 0, 1, 1, 0, 1, TS);
        ret("t5_mis2_ack", 39'h6200, 39'h8888, 1, 0, 1, 0, 1, 64'h6200);
        call("t5_call_c", 39'h6300, 0, 1, 1, 0, 1, 64'h6200);
        ret("t5_mis3_held", 39'h6400, 39'h1, 0, 0, 1, 0, 1, 64'h6200);
        idle("t5_ack", 1, 0, 1, 0, 0, 64'h6200);
        idle("t5_ack_none", 1, 0, 1, 0, 0, 64'h6200);
        call("t5_call_d", 39'h6600, 0, 1, 1, 0, 0, 64'h6200);
        drv("t5_en0_call", 0, 0, 0, 0, 1, 1, 0, 39'h6700, 0, '0, 0, 1, 1, 0, 0, 64'h6200);
        drv("t5_en0_ret", 0, 0, 0, 0, 1, 0, 1, 39'h6800, 0, 39'h6604, 0, 1, 1, 0, 0, 64'h6200);
        drv("t5_dbg_ret", 0, 0, 1, 1, 1, 0, 1, 39'h6900, 0, 39'h0, 0, 1, 1, 0, 0, 64'h6200);
        ret("t5_ret_d", 39'h6a00, 39'h6604, 0, 0, 1, 0, 0, 64'h6200);

        call("t6_call0", 39'h7000, 0, 1, 1, 0, 0, 64'h6200);
        call("t6_call1", 39'h7010, 0, 2, 1, 0, 0, 64'h6200);
        call("t6_call2", 39'h7020, 0, 3, 1, 0, 0, 64'h6200);
        ret("t6_mis", 39'h7100, 39'h0, 0, 2, 1, 0, 1, 64'h7100);
        call("t6_call3", 39'h7030, 0, 3, 1, 0, 1, 64'h7100);
        drv("t6_clear_call", 0, 1, 1, 0, 1, 1, 0, 39'h7040, 0, '0, 0, 0, 1, 0, 1, 64'h7100);
        ret("t6_ret_after", 39'h7200, 39'h0, 0, 0, 1, 1, 1, 64'h7100);
        idle("t6_ack", 1, 0, 1, 0, 0, 64'h7100);

        call("t7_call", 39'h7300, 0, 1, 1, 0, 0, 64'h7100);
        ret("t7_mis", 39'h7400, 39'h5, 0, 0, 1, 0, 1, 64'h7400);
        call("t7_call2", 39'h7500, 0, 1, 1, 0, 1, 64'h7400);
        drv("t7_reset", 1, 0, 1, 0, 1, 1, 0, 39'h7600, 0, '0, 0, 0, 0, 0, 0, 0);
        idle("t7_idle", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d pending expected %0d", sb.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
